// File: rtl/ysyx_24110006_axi_rd_arbiter_pkg.sv
// Shared configuration for the AXI read-path blocks.
// Holds the read-arbiter state encodings and grant indices, next to the
// ICACHE controller state constants so both FSMs share one source.
package ysyx_24110006_axi_rd_arbiter_pkg;

    // Read arbiter states
    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_AR   = 2'd1,
        ARB_R    = 2'd2
    } arb_state_e;

    // Grant index: which upstream master owns the downstream port
    localparam logic GNT_M0 = 1'b0;  // ICACHE
    localparam logic GNT_M1 = 1'b1;  // LSU

    // AXI burst types
    typedef enum logic [1:0] {
        AXI_BURST_FIXED = 2'b00,
        AXI_BURST_INCR  = 2'b01,
        AXI_BURST_WRAP  = 2'b10
    } axi_burst_e;

    // ICACHE controller states
    typedef enum logic [2:0] {
        IC_IDLE   = 3'd0,
        IC_LOOKUP = 3'd1,
        IC_MISS   = 3'd2,
        IC_REFILL = 3'd3,
        IC_FLUSH  = 3'd4
    } icache_state_e;

endpackage

// File: rtl/ysyx_24110006_rr_arb2.sv
// Two-requester tie-break.
// Ports:
//   req0, req1 : requests from M0 (ICACHE) and M1 (LSU)
//   last_gnt   : master served by the most recently completed transaction
//   gnt        : winning master index (valid when either request is high)
// FAIR=1 alternates on a tie; FAIR=0 lets M1 win every tie.
module ysyx_24110006_rr_arb2
    import ysyx_24110006_axi_rd_arbiter_pkg::*;
#(
    parameter bit FAIR = 1'b1
) (
    input  logic req0,
    input  logic req1,
    input  logic last_gnt,
    output logic gnt
);

    always_comb begin
        gnt = GNT_M0;
        if (req0 && req1) begin
            gnt = FAIR ? ~last_gnt : GNT_M1;
        end else if (req1) begin
            gnt = GNT_M1;
        end
    end

endmodule

// File: rtl/ysyx_24110006_axi_rd_arbiter.sv
// Two-master AXI read arbiter (M0 = ICACHE, M1 = LSU) onto one downstream
// port, one transaction outstanding at a time.
// Ports:
//   i_clock, i_reset        : clock, async active-high reset
//   i_m0_ar*/o_m0_arready   : M0 address channel
//   o_m0_r*/i_m0_rready     : M0 data channel
//   i_m1_ar*/o_m1_arready   : M1 address channel
//   o_m1_r*/i_m1_rready     : M1 data channel
//   o_axi_ar*/i_axi_arready : downstream address channel
//   i_axi_r*/o_axi_rready   : downstream data channel
//   o_busy                  : high whenever a transaction is in progress
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ARB_IDLE | no owner; arbitrate among arvalid requests
// ARB_AR   | granted master's address presented downstream
// ARB_R    | data beats routed to the granted master until rlast
module ysyx_24110006_axi_rd_arbiter
    import ysyx_24110006_axi_rd_arbiter_pkg::*;
#(
    parameter int FAIR = 1
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic [31:0] i_m0_araddr,
    input  logic        i_m0_arvalid,
    input  logic [3:0]  i_m0_arid,
    input  logic [7:0]  i_m0_arlen,
    input  logic [2:0]  i_m0_arsize,
    input  logic [1:0]  i_m0_arburst,
    output logic        o_m0_arready,
    output logic [31:0] o_m0_rdata,
    output logic [1:0]  o_m0_rresp,
    output logic [3:0]  o_m0_rid,
    output logic        o_m0_rlast,
    output logic        o_m0_rvalid,
    input  logic        i_m0_rready,
    input  logic [31:0] i_m1_araddr,
    input  logic        i_m1_arvalid,
    input  logic [3:0]  i_m1_arid,
    input  logic [7:0]  i_m1_arlen,
    input  logic [2:0]  i_m1_arsize,
    input  logic [1:0]  i_m1_arburst,
    output logic        o_m1_arready,
    output logic [31:0] o_m1_rdata,
    output logic [1:0]  o_m1_rresp,
    output logic [3:0]  o_m1_rid,
    output logic        o_m1_rlast,
    output logic        o_m1_rvalid,
    input  logic        i_m1_rready,
    output logic [31:0] o_axi_araddr,
    output logic        o_axi_arvalid,
    output logic [3:0]  o_axi_arid,
    output logic [7:0]  o_axi_arlen,
    output logic [2:0]  o_axi_arsize,
    output logic [1:0]  o_axi_arburst,
    input  logic        i_axi_arready,
    input  logic [31:0] i_axi_rdata,
    input  logic [1:0]  i_axi_rresp,
    input  logic [3:0]  i_axi_rid,
    input  logic        i_axi_rlast,
    input  logic        i_axi_rvalid,
    output logic        o_axi_rready,
    output logic        o_busy
);

    arb_state_e state_q, state_d;
    logic       gnt_q, gnt_d;
    logic       last_gnt_q, last_gnt_d;
    logic       arb_gnt;
    logic       sel_m1, sel_arvalid, sel_rready;
    logic       in_ar, in_r;

    ysyx_24110006_rr_arb2 #(
        .FAIR (FAIR != 0)
    ) u_rr_arb2 (
        .req0     (i_m0_arvalid),
        .req1     (i_m1_arvalid),
        .last_gnt (last_gnt_q),
        .gnt      (arb_gnt)
    );

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state_q    <= ARB_IDLE;
            gnt_q      <= GNT_M0;
            last_gnt_q <= GNT_M0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            last_gnt_q <= last_gnt_d;
        end
    end

    assign sel_m1      = (gnt_q == GNT_M1);
    assign sel_arvalid = sel_m1 ? i_m1_arvalid : i_m0_arvalid;
    assign sel_rready  = sel_m1 ? i_m1_rready  : i_m0_rready;
    assign in_ar       = (state_q == ARB_AR);
    assign in_r        = (state_q == ARB_R);

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        last_gnt_d = last_gnt_q;
        case (state_q)
            ARB_IDLE: begin
                if (i_m0_arvalid || i_m1_arvalid) begin
                    state_d = ARB_AR;
                    gnt_d   = arb_gnt;
                end
            end
            ARB_AR: begin
                // A withdrawn request is not a completed service, so the
                // round-robin history stays as it was.
                if (!sel_arvalid) begin
                    state_d = ARB_IDLE;
                end else if (i_axi_arready) begin
                    state_d = ARB_R;
                end
            end
            ARB_R: begin
                // Only the last beat frees the port; flushes upstream still
                // wait for the burst to drain.
                if (i_axi_rvalid && sel_rready && i_axi_rlast) begin
                    state_d    = ARB_IDLE;
                    last_gnt_d = gnt_q;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    assign o_axi_araddr  = sel_m1 ? i_m1_araddr  : i_m0_araddr;
    assign o_axi_arid    = sel_m1 ? i_m1_arid    : i_m0_arid;
    assign o_axi_arlen   = sel_m1 ? i_m1_arlen   : i_m0_arlen;
    assign o_axi_arsize  = sel_m1 ? i_m1_arsize  : i_m0_arsize;
    assign o_axi_arburst = sel_m1 ? i_m1_arburst : i_m0_arburst;
    assign o_axi_arvalid = in_ar & sel_arvalid;
    assign o_m0_arready  = in_ar & ~sel_m1 & i_axi_arready;
    assign o_m1_arready  = in_ar &  sel_m1 & i_axi_arready;

    assign o_m0_rdata  = i_axi_rdata;
    assign o_m0_rresp  = i_axi_rresp;
    assign o_m0_rid    = i_axi_rid;
    assign o_m0_rlast  = i_axi_rlast;
    assign o_m1_rdata  = i_axi_rdata;
    assign o_m1_rresp  = i_axi_rresp;
    assign o_m1_rid    = i_axi_rid;
    assign o_m1_rlast  = i_axi_rlast;
    assign o_m0_rvalid = in_r & ~sel_m1 & i_axi_rvalid;
    assign o_m1_rvalid = in_r &  sel_m1 & i_axi_rvalid;

    // Outside the data phase any stray beat is swallowed so the slave
    // cannot stall (also covers bursts orphaned by reset).
    assign o_axi_rready = in_r ? sel_rready : 1'b1;
    assign o_busy       = (state_q != ARB_IDLE);

endmodule

// File: tb/tb_ysyx_24110006_axi_rd_arbiter.sv
module tb_ysyx_24110006_axi_rd_arbiter;
    import ysyx_24110006_axi_rd_arbiter_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [31:0] m0_araddr, m1_araddr;
    logic        m0_arvalid, m1_arvalid;
    logic [3:0]  m0_arid, m1_arid;
    logic [7:0]  m0_arlen, m1_arlen;
    logic [2:0]  m0_arsize, m1_arsize;
    logic [1:0]  m0_arburst, m1_arburst;
    logic        m0_rready, m1_rready, axi_arready;
    logic [31:0] axi_rdata;
    logic [1:0]  axi_rresp;
    logic [3:0]  axi_rid;
    logic        axi_rlast, axi_rvalid;

    // index 0: FAIR=1 instance, index 1: FAIR=0 instance
    logic [31:0] q_araddr [2];
    logic        q_arvalid [2];
    logic [3:0]  q_arid [2];
    logic [7:0]  q_arlen [2];
    logic [2:0]  q_arsize [2];
    logic [1:0]  q_arburst [2];
    logic        q_m0_arready [2], q_m1_arready [2];
    logic [31:0] q_m0_rdata [2], q_m1_rdata [2];
    logic [1:0]  q_m0_rresp [2], q_m1_rresp [2];
    logic [3:0]  q_m0_rid [2], q_m1_rid [2];
    logic        q_m0_rlast [2], q_m1_rlast [2];
    logic        q_m0_rvalid [2], q_m1_rvalid [2];
    logic        q_rready [2], q_busy [2];

    for (genvar k = 0; k < 2; k++) begin : g_dut
        ysyx_24110006_axi_rd_arbiter #(.FAIR(k == 0 ? 1 : 0)) u_dut (
            .i_clock(clk), .i_reset(rst),
            .i_m0_araddr(m0_araddr), .i_m0_arvalid(m0_arvalid), .i_m0_arid(m0_arid),
            .i_m0_arlen(m0_arlen), .i_m0_arsize(m0_arsize), .i_m0_arburst(m0_arburst),
            .o_m0_arready(q_m0_arready[k]),
            .o_m0_rdata(q_m0_rdata[k]), .o_m0_rresp(q_m0_rresp[k]), .o_m0_rid(q_m0_rid[k]),
            .o_m0_rlast(q_m0_rlast[k]), .o_m0_rvalid(q_m0_rvalid[k]), .i_m0_rready(m0_rready),
            .i_m1_araddr(m1_araddr), .i_m1_arvalid(m1_arvalid), .i_m1_arid(m1_arid),
            .i_m1_arlen(m1_arlen), .i_m1_arsize(m1_arsize), .i_m1_arburst(m1_arburst),
            .o_m1_arready(q_m1_arready[k]),
            .o_m1_rdata(q_m1_rdata[k]), .o_m1_rresp(q_m1_rresp[k]), .o_m1_rid(q_m1_rid[k]),
            .o_m1_rlast(q_m1_rlast[k]), .o_m1_rvalid(q_m1_rvalid[k]), .i_m1_rready(m1_rready),
            .o_axi_araddr(q_araddr[k]), .o_axi_arvalid(q_arvalid[k]), .o_axi_arid(q_arid[k]),
            .o_axi_arlen(q_arlen[k]), .o_axi_arsize(q_arsize[k]), .o_axi_arburst(q_arburst[k]),
            .i_axi_arready(axi_arready),
            .i_axi_rdata(axi_rdata), .i_axi_rresp(axi_rresp), .i_axi_rid(axi_rid),
            .i_axi_rlast(axi_rlast), .i_axi_rvalid(axi_rvalid), .o_axi_rready(q_rready[k]),
            .o_busy(q_busy[k])
        );
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        m0_arvalid = 0; m1_arvalid = 0; axi_arready = 0;
        m0_rready = 0; m1_rready = 0;
        axi_rvalid = 0; axi_rlast = 0; axi_rdata = 0; axi_rresp = 0; axi_rid = 0;
        m0_araddr = 32'h3000_0000; m0_arid = 4'h1; m0_arlen = 8'd1;
        m0_arsize = 3'd2; m0_arburst = AXI_BURST_INCR;
        m1_araddr = 32'h8000_0000; m1_arid = 4'h2; m1_arlen = 8'd0;
        m1_arsize = 3'd2; m1_arburst = AXI_BURST_INCR;
    endtask

    // Holds reset with every request and valid high; only o_axi_rready may be 1.
    task automatic do_reset();
        rst = 1;
        clear_inputs();
        m0_arvalid = 1; m1_arvalid = 1; axi_arready = 1;
        axi_rvalid = 1; m0_rready = 1; m1_rready = 1;
        repeat (2) @(negedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("rst%0d.arvalid", k), q_arvalid[k], 0);
            chk($sformatf("rst%0d.m0_arready", k), q_m0_arready[k], 0);
            chk($sformatf("rst%0d.m1_arready", k), q_m1_arready[k], 0);
            chk($sformatf("rst%0d.m0_rvalid", k), q_m0_rvalid[k], 0);
            chk($sformatf("rst%0d.m1_rvalid", k), q_m1_rvalid[k], 0);
            chk($sformatf("rst%0d.rready", k), q_rready[k], 1);
            chk($sformatf("rst%0d.busy", k), q_busy[k], 0);
        end
        clear_inputs();
        rst = 0;
    endtask

    // in = {m0_arvalid, m1_arvalid, arready, rvalid, rlast, m0_rready, m1_rready}
    // ex = {axi_arvalid, m0_arready, m1_arready, m0_rvalid, m1_rvalid, axi_rready, busy}
    typedef struct {
        logic [6:0]  in;
        logic [31:0] rd;
        logic [6:0]  ex;
        logic [31:0] addr;
    } vec_t;

    vec_t tbl [16];

    function automatic vec_t mk(input logic [6:0] in, input logic [31:0] rd,
                                input logic [6:0] ex, input logic [31:0] addr);
        vec_t v;
        v.in = in; v.rd = rd; v.ex = ex; v.addr = addr;
        return v;
    endfunction

    // Transaction-level reference: who owns the port and whether its address was taken.
    int owner [2];
    bit addressed [2];
    int last [2];

    task automatic rnd_cycle(input int cyc);
        for (int k = 0; k < 2; k++) begin
            bit in_addr, in_data, req_o, rdy_o;
            logic [31:0] a;
            in_addr = (owner[k] >= 0) && !addressed[k];
            in_data = (owner[k] >= 0) && addressed[k];
            req_o   = (owner[k] == 1) ? m1_arvalid : m0_arvalid;
            rdy_o   = (owner[k] == 1) ? m1_rready : m0_rready;
            a       = (owner[k] == 1) ? m1_araddr : m0_araddr;
            chk($sformatf("rnd%0d@%0d.arvalid", k, cyc), q_arvalid[k], in_addr && req_o);
            chk($sformatf("rnd%0d@%0d.m0_arready", k, cyc), q_m0_arready[k],
                in_addr && owner[k] == 0 && axi_arready);
            chk($sformatf("rnd%0d@%0d.m1_arready", k, cyc), q_m1_arready[k],
                in_addr && owner[k] == 1 && axi_arready);
            chk($sformatf("rnd%0d@%0d.m0_rvalid", k, cyc), q_m0_rvalid[k],
                in_data && owner[k] == 0 && axi_rvalid);
            chk($sformatf("rnd%0d@%0d.m1_rvalid", k, cyc), q_m1_rvalid[k],
                in_data && owner[k] == 1 && axi_rvalid);
            chk($sformatf("rnd%0d@%0d.rready", k, cyc), q_rready[k], in_data ? rdy_o : 1'b1);
            chk($sformatf("rnd%0d@%0d.busy", k, cyc), q_busy[k], owner[k] >= 0);
            chk($sformatf("rnd%0d@%0d.m1_rdata", k, cyc), q_m1_rdata[k], axi_rdata);
            if (in_addr && req_o) begin
                chk($sformatf("rnd%0d@%0d.araddr", k, cyc), q_araddr[k], a);
                chk($sformatf("rnd%0d@%0d.arlen", k, cyc), q_arlen[k],
                    (owner[k] == 1) ? m1_arlen : m0_arlen);
                chk($sformatf("rnd%0d@%0d.arid", k, cyc), q_arid[k],
                    (owner[k] == 1) ? m1_arid : m0_arid);
            end
            // advance the reference to the next cycle
            if (owner[k] < 0) begin
                if (m0_arvalid && m1_arvalid) begin
                    owner[k] = (k == 0) ? 1 - last[k] : 1;
                    addressed[k] = 0;
                end else if (m0_arvalid || m1_arvalid) begin
                    owner[k] = m1_arvalid ? 1 : 0;
                    addressed[k] = 0;
                end
            end else if (!addressed[k]) begin
                if (!req_o) owner[k] = -1;
                else if (axi_arready) addressed[k] = 1;
            end else if (axi_rvalid && rdy_o && axi_rlast) begin
                last[k] = owner[k];
                owner[k] = -1;
            end
        end
    endtask

    function automatic bit coin(input int pct);
        return $urandom_range(0, 99) < pct;
    endfunction

    initial begin
        int win_f [$];
        int win_p [$];
        bit saw_p_m0;
        int exp_f [4];

        // Directed sequence: M0 2-beat burst, unsolicited beat, M1 waiting behind M0.
        tbl[0]  = mk(7'b1000000, 32'h0,    7'b0000010, 32'h0);
        tbl[1]  = mk(7'b1000000, 32'h0,    7'b1000011, 32'h3000_0000);
        tbl[2]  = mk(7'b1000000, 32'h0,    7'b1000011, 32'h3000_0000);
        tbl[3]  = mk(7'b1010000, 32'h0,    7'b1100011, 32'h3000_0000);
        tbl[4]  = mk(7'b0001010, 32'hA1,   7'b0001011, 32'h0);
        tbl[5]  = mk(7'b0001110, 32'hB2,   7'b0001011, 32'h0);
        tbl[6]  = mk(7'b0000000, 32'h0,    7'b0000010, 32'h0);
        tbl[7]  = mk(7'b0001000, 32'hC3,   7'b0000010, 32'h0);
        tbl[8]  = mk(7'b1000000, 32'h0,    7'b0000010, 32'h0);
        tbl[9]  = mk(7'b1010000, 32'h0,    7'b1100011, 32'h3000_0000);
        tbl[10] = mk(7'b0111010, 32'hD4,   7'b0001011, 32'h0);
        tbl[11] = mk(7'b0111110, 32'hE5,   7'b0001011, 32'h0);
        tbl[12] = mk(7'b0110000, 32'h0,    7'b0000010, 32'h0);
        tbl[13] = mk(7'b0110000, 32'h0,    7'b1010011, 32'h8000_0000);
        tbl[14] = mk(7'b0001101, 32'hF6,   7'b0000111, 32'h0);
        tbl[15] = mk(7'b0000000, 32'h0,    7'b0000010, 32'h0);

        do_reset();
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            {m0_arvalid, m1_arvalid, axi_arready, axi_rvalid, axi_rlast, m0_rready, m1_rready} = tbl[i].in;
            axi_rdata = tbl[i].rd;
            #1;
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("vec%0d.%0d.arvalid", i, k), q_arvalid[k], tbl[i].ex[6]);
                chk($sformatf("vec%0d.%0d.m0_arready", i, k), q_m0_arready[k], tbl[i].ex[5]);
                chk($sformatf("vec%0d.%0d.m1_arready", i, k), q_m1_arready[k], tbl[i].ex[4]);
                chk($sformatf("vec%0d.%0d.m0_rvalid", i, k), q_m0_rvalid[k], tbl[i].ex[3]);
                chk($sformatf("vec%0d.%0d.m1_rvalid", i, k), q_m1_rvalid[k], tbl[i].ex[2]);
                chk($sformatf("vec%0d.%0d.rready", i, k), q_rready[k], tbl[i].ex[1]);
                chk($sformatf("vec%0d.%0d.busy", i, k), q_busy[k], tbl[i].ex[0]);
                chk($sformatf("vec%0d.%0d.m0_rdata", i, k), q_m0_rdata[k], tbl[i].rd);
                chk($sformatf("vec%0d.%0d.m1_rdata", i, k), q_m1_rdata[k], tbl[i].rd);
                if (tbl[i].ex[6])
                    chk($sformatf("vec%0d.%0d.araddr", i, k), q_araddr[k], tbl[i].addr);
            end
        end

        // Both masters held requesting from reset: record who wins each address phase.
        do_reset();
        m0_arvalid = 1; m1_arvalid = 1; axi_arready = 1;
        axi_rvalid = 1; axi_rlast = 1; m0_rready = 1; m1_rready = 1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk); #1;
            if (q_m0_arready[0]) win_f.push_back(0);
            if (q_m1_arready[0]) win_f.push_back(1);
            if (q_m0_arready[1]) win_p.push_back(0);
            if (q_m1_arready[1]) win_p.push_back(1);
        end
        exp_f = '{1, 0, 1, 0};
        chk("fair.count", win_f.size(), 4);
        chk("prio.count", win_p.size(), 4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("fair.win%0d", i), (i < win_f.size()) ? win_f[i] : -1, exp_f[i]);
            chk($sformatf("prio.win%0d", i), (i < win_p.size()) ? win_p[i] : -1, 1);
        end
        m1_arvalid = 0;
        saw_p_m0 = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk); #1;
            if (q_m0_arready[1]) saw_p_m0 = 1;
        end
        chk("prio.m0_after_m1_drops", saw_p_m0, 1);

        // Asynchronous reset in the middle of a data phase.
        do_reset();
        @(negedge clk);
        m0_arvalid = 1; axi_arready = 1;
        @(negedge clk);
        @(negedge clk);
        m0_arvalid = 0; axi_arready = 0;
        axi_rvalid = 1; axi_rlast = 0; m0_rready = 1;
        #1;
        chk("midr.pre_m0_rvalid", q_m0_rvalid[0], 1);
        #1 rst = 1;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("midr%0d.busy", k), q_busy[k], 0);
            chk($sformatf("midr%0d.m0_rvalid", k), q_m0_rvalid[k], 0);
            chk($sformatf("midr%0d.m1_rvalid", k), q_m1_rvalid[k], 0);
            chk($sformatf("midr%0d.rready", k), q_rready[k], 1);
        end
        @(negedge clk);
        rst = 0;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("drain%0d.rready", k), q_rready[k], 1);
            chk($sformatf("drain%0d.m0_rvalid", k), q_m0_rvalid[k], 0);
        end

        // Randomized traffic against the reference model.
        do_reset();
        for (int k = 0; k < 2; k++) begin
            owner[k] = -1; addressed[k] = 0; last[k] = 0;
        end
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            m0_arvalid = m0_arvalid ? coin(85) : coin(30);
            m1_arvalid = m1_arvalid ? coin(85) : coin(30);
            m0_araddr = $urandom; m1_araddr = $urandom;
            m0_arlen = 8'($urandom); m1_arlen = 8'($urandom);
            m0_arid = 4'($urandom); m1_arid = 4'($urandom);
            axi_arready = coin(50);
            axi_rvalid = coin(50);
            axi_rlast = coin(40);
            m0_rready = coin(70);
            m1_rready = coin(70);
            axi_rdata = $urandom;
            #1;
            rnd_cycle(cyc);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
